// File: rtl/tm_mem_req_queue.sv
// tm_mem_req_queue: request buffer and round-robin arbiter in front of the
// manycore memory-system timing model. I-cache and D-cache requests are
// arbitrated, buffered in a DEPTH-entry FIFO and issued one per cycle on a
// registered request port. Optional statistics counters are enabled by
// defining TM_MEMQ_STATS_EN.

package tm_mem_req_queue_pkg;

  typedef struct packed {
    logic clk;
  } iu_clk_type;

  typedef struct packed {
    logic [3:0]  tid;
    logic [1:0]  partitionid;
    logic        request_valid;
    logic [31:0] request_addr;
    logic        writeback_valid;
    logic [31:0] writeback_addr;
    logic        token_valid;
  } tm_mem_request_t;

  typedef struct packed {
    logic [31:0] stall_cycles;
    logic [31:0] full_cycles;
    logic [31:0] d_grants;
  } tm_memq_ctrs_t;

endpackage

module tm_mem_req_queue
  import tm_mem_req_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  iu_clk_type              gclk,
  input  logic                    rst,
  input  logic                    run_reg,
  input  logic                    i_req_valid,
  input  logic                    d_req_valid,
  output logic                    i_req_ready,
  output logic                    d_req_ready,
  input  tm_mem_request_t         i_req,
  input  tm_mem_request_t         d_req,
  input  logic                    token_valid,
  input  logic                    stay_stalled,
  output tm_mem_request_t         req,
  output logic [$clog2(DEPTH):0]  q_count
`ifdef TM_MEMQ_STATS_EN
  ,
  output tm_memq_ctrs_t           memq_ctrs
`endif
);

  // DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  logic clk;
  assign clk = gclk.clk;

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW:0]     count_q, count_d;
  logic            last_grant_q, last_grant_d;
  tm_mem_request_t req_q, req_d;
  tm_mem_request_t mem_q [DEPTH];
  tm_mem_request_t mem_d [DEPTH];

  logic            space;
  logic            grant_i;
  logic            grant_d;
  logic            push;
  logic            pop;
  tm_mem_request_t push_sel;

  // Arbitration from registered occupancy only: a same-cycle pop never frees space.
  always_comb begin
    space    = (count_q < DEPTH_C);
    grant_i  = i_req_valid & (~d_req_valid | last_grant_q) & space & ~rst;
    grant_d  = d_req_valid & (~i_req_valid | ~last_grant_q) & space & ~rst;
    push_sel = grant_d ? d_req : i_req;
    push     = (grant_i | grant_d) & (push_sel.request_valid | push_sel.writeback_valid);
    pop      = run_reg & ~stay_stalled & (count_q != '0);
  end

  assign i_req_ready = grant_i;
  assign d_req_ready = grant_d;
  assign req         = req_q;
  assign q_count     = count_q;

  // Next-state for FIFO, pointers, occupancy, grant history and issue register.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    last_grant_d = last_grant_q;
    mem_d        = mem_q;
    req_d        = req_q;

    if (push) begin
      mem_d[wr_ptr_q] = push_sel;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end

    if (pop) begin
      req_d    = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      req_d.request_valid   = 1'b0;
      req_d.writeback_valid = 1'b0;
    end
    req_d.token_valid = token_valid;

    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase

    if (grant_i) begin
      last_grant_d = 1'b0;
    end else if (grant_d) begin
      last_grant_d = 1'b1;
    end
  end

  // Control state and issue register; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      last_grant_q <= 1'b1;
      req_q        <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
      req_q        <= req_d;
    end
  end

  // Entry storage needs no reset; stale slots are never read past the count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef TM_MEMQ_STATS_EN
  tm_memq_ctrs_t stats_q, stats_d;

  // Saturating event counters for stalled-head, full and D-grant cycles.
  always_comb begin
    stats_d = stats_q;
    if (stay_stalled && (count_q != '0) && (stats_q.stall_cycles != '1)) begin
      stats_d.stall_cycles = stats_q.stall_cycles + 32'd1;
    end
    if ((count_q == DEPTH_C) && (stats_q.full_cycles != '1)) begin
      stats_d.full_cycles = stats_q.full_cycles + 32'd1;
    end
    if (grant_d && (stats_q.d_grants != '1)) begin
      stats_d.d_grants = stats_q.d_grants + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stats_q <= '0;
    end else begin
      stats_q <= stats_d;
    end
  end

  assign memq_ctrs = stats_q;
`endif

endmodule

// File: tb/tb_tm_mem_req_queue.sv
// Testbench for tm_mem_req_queue: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model of the request buffer.

module tb_tm_mem_req_queue;
  import tm_mem_req_queue_pkg::*;

  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  iu_clk_type      gclk;
  logic            rst;
  logic            run_reg;
  logic            i_req_valid;
  logic            d_req_valid;
  logic            i_req_ready;
  logic            d_req_ready;
  tm_mem_request_t i_req;
  tm_mem_request_t d_req;
  logic            token_valid;
  logic            stay_stalled;
  tm_mem_request_t req;
  logic [2:0]      q_count;
`ifdef TM_MEMQ_STATS_EN
  tm_memq_ctrs_t   memq_ctrs;
`endif

  assign gclk.clk = clk;
  always #5 clk = ~clk;

  tm_mem_req_queue #(.DEPTH(DEPTH)) dut (
    .gclk         (gclk),
    .rst          (rst),
    .run_reg      (run_reg),
    .i_req_valid  (i_req_valid),
    .d_req_valid  (d_req_valid),
    .i_req_ready  (i_req_ready),
    .d_req_ready  (d_req_ready),
    .i_req        (i_req),
    .d_req        (d_req),
    .token_valid  (token_valid),
    .stay_stalled (stay_stalled),
    .req          (req),
    .q_count      (q_count)
`ifdef TM_MEMQ_STATS_EN
    ,
    .memq_ctrs    (memq_ctrs)
`endif
  );

  // Reference model: a queue of buffered requests, the identity of the last
  // granted source, and the request the memory system should currently see.
  tm_mem_request_t m_fifo [$];
  logic            m_last = 1'b1;
  tm_mem_request_t m_req  = '0;

  int n_vec = 0;
  int n_err = 0;

  function automatic logic model_grant_i();
    if (rst || m_fifo.size() >= DEPTH || !i_req_valid) return 1'b0;
    if (!d_req_valid) return 1'b1;
    return m_last == 1'b1;
  endfunction

  function automatic logic model_grant_d();
    if (rst || m_fifo.size() >= DEPTH || !d_req_valid) return 1'b0;
    if (!i_req_valid) return 1'b1;
    return m_last == 1'b0;
  endfunction

  // Advances the model by one clock edge using the inputs present at the edge.
  task automatic model_update();
    tm_mem_request_t entry;
    logic gi, gd;
    if (rst) begin
      m_fifo.delete();
      m_last = 1'b1;
      m_req  = '0;
      return;
    end
    gi = model_grant_i();
    gd = model_grant_d();
    if (run_reg && !stay_stalled && m_fifo.size() > 0) begin
      m_req = m_fifo.pop_front();
    end else begin
      m_req.request_valid   = 1'b0;
      m_req.writeback_valid = 1'b0;
    end
    m_req.token_valid = token_valid;
    if (gi || gd) begin
      entry  = gd ? d_req : i_req;
      m_last = gd;
      if (entry.request_valid || entry.writeback_valid) m_fifo.push_back(entry);
    end
  endtask

  // One clock: edge, model step, then settle at the falling edge.
  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  function automatic tm_mem_request_t mk_req(logic [31:0] addr, logic rv, logic wv);
    tm_mem_request_t r;
    r.tid             = 4'($urandom);
    r.partitionid     = 2'($urandom);
    r.request_valid   = rv;
    r.request_addr    = addr;
    r.writeback_valid = wv;
    r.writeback_addr  = $urandom;
    r.token_valid     = 1'($urandom);
    return r;
  endfunction

  task automatic idle();
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    i_req       = '0;
    d_req       = '0;
  endtask

  task automatic do_reset();
    idle();
    rst          = 1'b1;
    stay_stalled = 1'b0;
    run_reg      = 1'b1;
    token_valid  = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    run_reg      = 1'b1;
    stay_stalled = 1'b0;
    token_valid  = 1'b1;
    i_req_valid  = 1'b1;
    d_req_valid  = 1'b1;
    i_req        = mk_req(32'h0000_0100, 1'b1, 1'b0);
    d_req        = mk_req(32'h0000_0200, 1'b1, 1'b0);
    #1;
    n_vec++;
    if (i_req_ready !== 1'b0 || d_req_ready !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL reset_ready: got i=%b d=%b expected i=0 d=0", i_req_ready, d_req_ready);
    end
    tick();
    tick();
    n_vec++;
    if (req !== '0) begin
      n_err++;
      $display("[TB] FAIL reset_req: got %h expected 0", req);
    end
    n_vec++;
    if (q_count !== 3'd0) begin
      n_err++;
      $display("[TB] FAIL reset_count: got %0d expected 0", q_count);
    end
    rst         = 1'b0;
    token_valid = 1'b0;
    idle();
    tick();
  endtask

  task automatic test_single_request();
    do_reset();
    tick();
    d_req_valid = 1'b1;
    d_req       = mk_req(32'h0000_1040, 1'b1, 1'b0);
    #1;
    n_vec++;
    if (d_req_ready !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL single_ready: got %b expected 1", d_req_ready);
    end
    tick();
    idle();
    n_vec++;
    if (req.request_valid !== 1'b0 || q_count !== 3'd1) begin
      n_err++;
      $display("[TB] FAIL single_accept: got rv=%b cnt=%0d expected rv=0 cnt=1", req.request_valid, q_count);
    end
    tick();
    n_vec++;
    if (req.request_valid !== 1'b1 || req.request_addr !== 32'h0000_1040 || q_count !== 3'd0) begin
      n_err++;
      $display("[TB] FAIL single_issue: got rv=%b addr=%h cnt=%0d expected rv=1 addr=00001040 cnt=0",
               req.request_valid, req.request_addr, q_count);
    end
    n_vec++;
    if (req !== m_req) begin
      n_err++;
      $display("[TB] FAIL single_payload: got %h expected %h", req, m_req);
    end
    tick();
    n_vec++;
    if (req.request_valid !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL single_once: got rv=%b expected 0", req.request_valid);
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] granted [$];
    do_reset();
    for (int k = 0; k < 10; k++) begin
      i_req_valid = 1'b1;
      d_req_valid = 1'b1;
      i_req       = mk_req(32'h0000_1000 + k, 1'b1, 1'b0);
      d_req       = mk_req(32'h0000_2000 + k, 1'b1, 1'b0);
      #1;
      n_vec++;
      if (i_req_ready !== ((k % 2) == 0) || d_req_ready !== ((k % 2) == 1)) begin
        n_err++;
        $display("[TB] FAIL rr_grant[%0d]: got i=%b d=%b expected i=%b d=%b",
                 k, i_req_ready, d_req_ready, (k % 2) == 0, (k % 2) == 1);
      end
      granted.push_back(((k % 2) == 0) ? 32'h0000_1000 + k : 32'h0000_2000 + k);
      tick();
      if (k >= 1) begin
        n_vec++;
        if (req.request_valid !== 1'b1 || req.request_addr !== granted[k-1]) begin
          n_err++;
          $display("[TB] FAIL rr_issue[%0d]: got rv=%b addr=%h expected rv=1 addr=%h",
                   k, req.request_valid, req.request_addr, granted[k-1]);
        end
        n_vec++;
        if (req !== m_req || q_count !== 3'(m_fifo.size())) begin
          n_err++;
          $display("[TB] FAIL rr_model[%0d]: got %h/%0d expected %h/%0d", k, req, q_count, m_req, m_fifo.size());
        end
      end
    end
    idle();
    tick();
    tick();
  endtask

  task automatic test_back_pressure();
    int acc;
    do_reset();
    stay_stalled = 1'b1;
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      d_req_valid = 1'b1;
      d_req       = mk_req(32'h0000_3000 + k, 1'b1, 1'b0);
      #1;
      n_vec++;
      if (d_req_ready !== model_grant_d()) begin
        n_err++;
        $display("[TB] FAIL bp_ready[%0d]: got %b expected %b", k, d_req_ready, model_grant_d());
      end
      if (d_req_ready === 1'b1) acc++;
      tick();
    end
    n_vec++;
    if (acc != 4 || q_count !== 3'd4 || d_req_ready !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL bp_full: got acc=%0d cnt=%0d rdy=%b expected acc=4 cnt=4 rdy=0", acc, q_count, d_req_ready);
    end
    n_vec++;
    if (req.request_valid !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL bp_stalled: got rv=%b expected 0", req.request_valid);
    end
    idle();
    stay_stalled = 1'b0;
    for (int j = 0; j < 4; j++) begin
      tick();
      n_vec++;
      if (req.request_valid !== 1'b1 || req.request_addr !== 32'h0000_3000 + j) begin
        n_err++;
        $display("[TB] FAIL bp_drain[%0d]: got rv=%b addr=%h expected rv=1 addr=%h",
                 j, req.request_valid, req.request_addr, 32'h0000_3000 + j);
      end
    end
    d_req_valid = 1'b1;
    d_req       = mk_req(32'h0000_3fff, 1'b1, 1'b0);
    #1;
    n_vec++;
    if (q_count !== 3'd0 || d_req_ready !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL bp_reopen: got cnt=%0d rdy=%b expected cnt=0 rdy=1", q_count, d_req_ready);
    end
    idle();
  endtask

  task automatic test_full_push_pop();
    do_reset();
    stay_stalled = 1'b1;
    for (int k = 0; k < 4; k++) begin
      d_req_valid = 1'b1;
      d_req       = mk_req(32'h0000_4000 + k, 1'b1, 1'b0);
      tick();
    end
    stay_stalled = 1'b0;
    d_req        = mk_req(32'h0000_4444, 1'b1, 1'b0);
    #1;
    n_vec++;
    if (d_req_ready !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL full_noaccept: got %b expected 0", d_req_ready);
    end
    tick();
    n_vec++;
    if (q_count !== 3'd3 || req.request_addr !== 32'h0000_4000) begin
      n_err++;
      $display("[TB] FAIL full_pop: got cnt=%0d addr=%h expected cnt=3 addr=00004000", q_count, req.request_addr);
    end
    #1;
    n_vec++;
    if (d_req_ready !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL full_reaccept: got %b expected 1", d_req_ready);
    end
    tick();
    n_vec++;
    if (q_count !== 3'd3 || req.request_addr !== 32'h0000_4001) begin
      n_err++;
      $display("[TB] FAIL full_pushpop: got cnt=%0d addr=%h expected cnt=3 addr=00004001", q_count, req.request_addr);
    end
    idle();
    for (int j = 0; j < 4; j++) begin
      tick();
      n_vec++;
      if (req !== m_req || q_count !== 3'(m_fifo.size())) begin
        n_err++;
        $display("[TB] FAIL full_drain[%0d]: got %h/%0d expected %h/%0d", j, req, q_count, m_req, m_fifo.size());
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int leaked;
    do_reset();
    stay_stalled = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_req_valid = 1'b1;
      i_req       = mk_req(32'h0000_5000 + k, 1'b1, 1'b1);
      tick();
    end
    rst         = 1'b1;
    d_req_valid = 1'b1;
    d_req       = mk_req(32'h0000_5555, 1'b1, 1'b0);
    #1;
    n_vec++;
    if (i_req_ready !== 1'b0 || d_req_ready !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL midrst_ready: got i=%b d=%b expected 0 0", i_req_ready, d_req_ready);
    end
    tick();
    rst = 1'b0;
    idle();
    n_vec++;
    if (q_count !== 3'd0 || req !== '0) begin
      n_err++;
      $display("[TB] FAIL midrst_state: got cnt=%0d req=%h expected cnt=0 req=0", q_count, req);
    end
    stay_stalled = 1'b0;
    leaked = 0;
    for (int j = 0; j < 6; j++) begin
      tick();
      if (req.request_valid !== 1'b0 || req.writeback_valid !== 1'b0 || q_count !== 3'd0) leaked++;
    end
    n_vec++;
    if (leaked != 0) begin
      n_err++;
      $display("[TB] FAIL midrst_dropped: got %0d issuing cycles expected 0", leaked);
    end
  endtask

  task automatic test_empty_payload();
    do_reset();
    d_req_valid = 1'b1;
    d_req       = mk_req(32'h0000_6000, 1'b0, 1'b0);
    #1;
    n_vec++;
    if (d_req_ready !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL empty_ready: got %b expected 1", d_req_ready);
    end
    tick();
    idle();
    n_vec++;
    if (q_count !== 3'd0) begin
      n_err++;
      $display("[TB] FAIL empty_count: got %0d expected 0", q_count);
    end
    tick();
    n_vec++;
    if (req.request_valid !== 1'b0 || req.writeback_valid !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL empty_issue: got rv=%b wv=%b expected 0 0", req.request_valid, req.writeback_valid);
    end
  endtask

  task automatic test_random();
    logic [1:0] f;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      rst          = ($urandom_range(0, 39) == 0);
      run_reg      = ($urandom_range(0, 9) != 0);
      stay_stalled = ($urandom_range(0, 9) < 3);
      token_valid  = 1'($urandom);
      i_req_valid  = ($urandom_range(0, 9) < 6);
      d_req_valid  = ($urandom_range(0, 9) < 6);
      f            = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      i_req        = mk_req($urandom, f[0], f[1]);
      f            = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      d_req        = mk_req($urandom, f[0], f[1]);
      #1;
      n_vec++;
      if (i_req_ready !== model_grant_i() || d_req_ready !== model_grant_d()) begin
        n_err++;
        $display("[TB] FAIL rand_ready[%0d]: got i=%b d=%b expected i=%b d=%b",
                 k, i_req_ready, d_req_ready, model_grant_i(), model_grant_d());
      end
      tick();
      n_vec++;
      if (req !== m_req || q_count !== 3'(m_fifo.size())) begin
        n_err++;
        $display("[TB] FAIL rand_out[%0d]: got %h/%0d expected %h/%0d", k, req, q_count, m_req, m_fifo.size());
      end
      n_vec++;
      if (q_count > 3'(DEPTH)) begin
        n_err++;
        $display("[TB] FAIL rand_overflow[%0d]: got %0d expected <= %0d", k, q_count, DEPTH);
      end
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    test_reset();
    test_single_request();
    test_simultaneous();
    test_back_pressure();
    test_full_push_pop();
    test_reset_mid_run();
    test_empty_payload();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
